// File: rtl/obi_host_master.sv
// Single-outstanding OBI host: one command becomes one OBI transaction. rsp_valid_o follows rvalid_i by one cycle.
// A command is accepted only in IDLE and is not buffered. Each phase gives up after pTIMEOUT cycles and reports an error.
module obi_host_master #(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     cmd_valid_i,
  input  logic                     cmd_we_i,
  input  logic [pDATA_WIDTH/8-1:0] cmd_be_i,
  input  logic                     cmd_inc_i,
  input  logic [pADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [pDATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                     cmd_ready_o,
  output logic                     rsp_valid_o,
  output logic                     rsp_err_o,
  output logic [pDATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                     busy_o,
  output logic [15:0]              txn_count_o,
  output logic                     req_o,
  output logic                     we_o,
  output logic [pDATA_WIDTH/8-1:0] be_o,
  output logic [pADDR_WIDTH-1:0]   addr_o,
  output logic [pDATA_WIDTH-1:0]   wdata_o,
  input  logic                     gnt_i,
  input  logic                     rvalid_i,
  input  logic [pDATA_WIDTH-1:0]   rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam logic [15:0]            PHASE_LAST = 16'(pTIMEOUT - 1);
  localparam logic [pADDR_WIDTH-1:0] ALIGN_MSK  = {{(pADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [pADDR_WIDTH-1:0] WORD_STEP  = pADDR_WIDTH'(4);

  state_t                   state;
  logic [15:0]              phase_cnt;
  logic [pADDR_WIDTH-1:0]   ptr;
  logic [pADDR_WIDTH-1:0]   next_addr;
  logic                     phase_exp;

  assign next_addr   = (cmd_inc_i ? ptr : cmd_addr_i) & ALIGN_MSK;
  assign phase_exp   = (phase_cnt == PHASE_LAST);
  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      ptr         <= '0;
      req_o       <= 1'b0;
      we_o        <= 1'b0;
      be_o        <= '0;
      addr_o      <= '0;
      wdata_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      txn_count_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            we_o      <= cmd_we_i;
            be_o      <= cmd_be_i;
            wdata_o   <= cmd_wdata_i;
            addr_o    <= next_addr;
            req_o     <= 1'b1;
            phase_cnt <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          // A grant in the expiry cycle still wins over the timeout.
          if (gnt_i) begin
            req_o     <= 1'b0;
            phase_cnt <= '0;
            state     <= RSP;
          end else if (phase_exp) begin
            req_o       <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            phase_cnt   <= '0;
            state       <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        RSP: begin
          if (rvalid_i) begin
            rsp_valid_o <= 1'b1;
            if (!we_o) rsp_rdata_o <= rdata_i;
            txn_count_o <= txn_count_o + 16'd1;
            ptr         <= addr_o + WORD_STEP;
            phase_cnt   <= '0;
            state       <= IDLE;
          end else if (phase_exp) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            phase_cnt   <= '0;
            state       <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        default: begin
          req_o     <= 1'b0;
          phase_cnt <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
